// File: rtl/localassign_seq.sv
// Registered sequencer driving a combinational per-state output stage: latches an (a,b)
// token, walks state codes 0..NUM_POST and streams the sampled o_in one result per code.
module localassign_seq #(
    parameter int         NUM_POST  = 3,     // 0..3
    parameter logic [2:0] IDLE_CODE = 3'd4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_a,
    input  logic       in_b,
    output logic [2:0] state,
    output logic       a,
    output logic       b,
    input  logic       o_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_data,
    output logic [7:0] token_count
);

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the producer
    // holds data stable while valid is high, and ready never depends on valid.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_POST1 = 3'd2,
        S_POST2 = 3'd3,
        S_POST3 = 3'd4
    } fsm_t;

    fsm_t       fsm;
    logic [2:0] step;       // code being evaluated: 0 in EVAL, k in POSTk
    logic       last_step;
    logic       adv;

    always_comb begin
        step      = 3'(fsm - 3'd1);
        last_step = (step == 3'(NUM_POST));
        adv       = !out_valid || out_ready;
        in_ready  = (fsm == S_IDLE) && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm         <= S_IDLE;
            state       <= IDLE_CODE;
            a           <= 1'b0;
            b           <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 1'b0;
            token_count <= 8'd0;
        end else begin
            // Drain by default; a load below in the same cycle keeps out_valid high.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a     <= in_a;
                        b     <= in_b;
                        fsm   <= S_EVAL;
                        state <= 3'd0;
                    end
                end
                default: begin
                    if (adv) begin
                        out_data  <= o_in;
                        out_valid <= 1'b1;
                        if (last_step) begin
                            fsm         <= S_IDLE;
                            state       <= IDLE_CODE;
                            token_count <= token_count + 8'd1;
                        end else begin
                            fsm   <= fsm_t'(fsm + 3'd1);
                            state <= 3'(step + 3'd1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_localassign_seq.sv
// Bench for localassign_seq: a NUM_POST=3 and a NUM_POST=0 instance, each with a model of
// the downstream stage and a token-level result queue.
module tb_localassign_seq;

    logic clock;
    logic reset;

    logic       in_valid_3, in_ready_3, in_a_3, in_b_3, a_3, b_3, o_in_3;
    logic       out_valid_3, out_ready_3, out_data_3;
    logic [2:0] state_3;
    logic [7:0] token_count_3;

    logic       in_valid_0, in_ready_0, in_a_0, in_b_0, a_0, b_0, o_in_0;
    logic       out_valid_0, out_ready_0, out_data_0;
    logic [2:0] state_0;
    logic [7:0] token_count_0;

    int checks = 0;
    int errors = 0;

    logic exp_q3[$];
    logic exp_q0[$];
    int   pops3 = 0;
    int   acc3  = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- downstream stage model ----------------
    function automatic logic stage_o(input logic [2:0] s, input logic sa, input logic sb);
        case (s)
            3'd0:    return (sa ^ sb) ^ sa;
            3'd1:    return 1'b0;
            3'd2:    return 1'b1;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign o_in_3 = stage_o(state_3, a_3, b_3);
    assign o_in_0 = stage_o(state_0, a_0, b_0);

    localassign_seq #(.NUM_POST(3), .IDLE_CODE(3'd4)) dut3 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_3), .in_ready(in_ready_3), .in_a(in_a_3), .in_b(in_b_3),
        .state(state_3), .a(a_3), .b(b_3), .o_in(o_in_3),
        .out_valid(out_valid_3), .out_ready(out_ready_3), .out_data(out_data_3),
        .token_count(token_count_3)
    );

    localassign_seq #(.NUM_POST(0), .IDLE_CODE(3'd4)) dut0 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_0), .in_ready(in_ready_0), .in_a(in_a_0), .in_b(in_b_0),
        .state(state_0), .a(a_0), .b(b_0), .o_in(o_in_0),
        .out_valid(out_valid_0), .out_ready(out_ready_0), .out_data(out_data_0),
        .token_count(token_count_0)
    );

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle3(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (state_3 == 3'd4 && !out_valid_3) break;
            tick();
        end
        check(tag, {state_3, out_valid_3}, {3'd4, 1'b0});
    endtask

    // Token -> result list: entry 0 is (a^b)^a, then 0, 1, 1, truncated to NUM_POST+1.
    function automatic logic token_result(input int k, input logic ta, input logic tb);
        logic [3:0] seq;
        seq = {1'b1, 1'b1, 1'b0, (ta ^ tb) ^ ta};
        return seq[k];
    endfunction

    // ---------------- scoreboards ----------------
    always @(negedge clock) begin
        if (reset) begin
            exp_q3.delete();
            exp_q0.delete();
            acc3 = 0;
        end else begin
            if (out_valid_3 && out_ready_3) begin
                pops3++;
                if (exp_q3.size() == 0) check("unexpected_out3", 1, 0);
                else check("out_data3", out_data_3, exp_q3.pop_front());
            end
            if (out_valid_0 && out_ready_0) begin
                if (exp_q0.size() == 0) check("unexpected_out0", 1, 0);
                else check("out_data0", out_data_0, exp_q0.pop_front());
            end
            if (in_valid_3 && in_ready_3) begin
                acc3++;
                for (int k = 0; k <= 3; k++) exp_q3.push_back(token_result(k, in_a_3, in_b_3));
            end
            if (in_valid_0 && in_ready_0) begin
                exp_q0.push_back(token_result(0, in_a_0, in_b_0));
            end
        end
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [2:0] exp_st [4];
        logic       exp_d  [4];
        int         acc_cyc [3];
        int         tok_idx;
        int         ready_cnt;
        int         pops_before;
        logic [1:0] toks [3];

        reset = 1'b1;
        in_valid_3 = 0; in_a_3 = 0; in_b_3 = 0; out_ready_3 = 1;
        in_valid_0 = 0; in_a_0 = 0; in_b_0 = 0; out_ready_0 = 1;
        tick(); tick();
        check("rst_state", state_3, 3'd4);
        check("rst_out_valid", out_valid_3, 0);
        check("rst_out_data", out_data_3, 0);
        check("rst_token_count", token_count_3, 0);
        check("rst_ab", {a_3, b_3}, 2'b00);
        check("rst_in_ready", in_ready_3, 0);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready_3, 1);

        // Single token a=1,b=0
        exp_st = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_d  = '{1'b0, 1'b0, 1'b1, 1'b1};
        in_valid_3 = 1; in_a_3 = 1; in_b_3 = 0;
        tick();
        in_valid_3 = 0;
        check("t1_state_eval", state_3, 3'd0);
        check("t1_no_early_valid", out_valid_3, 0);
        check("t1_in_ready_busy", in_ready_3, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_state", state_3, exp_st[i]);
            check("t1_out_valid", out_valid_3, 1);
            check("t1_out_data", out_data_3, exp_d[i]);
        end
        check("t1_token_count", token_count_3, 1);
        tick();
        check("t1_drained", out_valid_3, 0);

        // Back-to-back tokens, in_valid held high
        toks = '{2'b00, 2'b01, 2'b11};
        tok_idx = 0;
        ready_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (tok_idx < 3) begin
                in_valid_3 = 1;
                {in_a_3, in_b_3} = toks[tok_idx];
            end else begin
                in_valid_3 = 0;
            end
            #0;
            if (in_valid_3 && in_ready_3) begin
                acc_cyc[tok_idx] = c;
                tok_idx++;
                ready_cnt++;
            end
            tick();
        end
        in_valid_3 = 0;
        check("t2_accepted", ready_cnt, 3);
        check("t2_gap1", acc_cyc[1] - acc_cyc[0], 5);
        check("t2_gap2", acc_cyc[2] - acc_cyc[1], 5);
        wait_idle3("t2_idle");
        check("t2_token_count", token_count_3, 4);

        // Stall during POST1
        pops_before = pops3;
        in_valid_3 = 1; in_a_3 = 1; in_b_3 = 0;
        tick();
        in_valid_3 = 0;
        tick();
        check("t3_state_post1", state_3, 3'd1);
        out_ready_3 = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_state", state_3, 3'd1);
            check("t3_stall_valid", out_valid_3, 1);
            check("t3_stall_data", out_data_3, 0);
        end
        out_ready_3 = 1;
        wait_idle3("t3_idle");
        check("t3_results", pops3 - pops_before, 4);
        check("t3_token_count", token_count_3, 5);

        // Reset during POST2
        in_valid_3 = 1; in_a_3 = 0; in_b_3 = 1;
        tick();
        in_valid_3 = 0;
        for (int i = 0; i < 10; i++) begin
            if (state_3 == 3'd2) break;
            tick();
        end
        check("t4_reached_post2", state_3, 3'd2);
        reset = 1;
        tick();
        check("t4_rst_state", state_3, 3'd4);
        check("t4_rst_valid", out_valid_3, 0);
        check("t4_rst_count", token_count_3, 0);
        reset = 0;
        #1;
        check("t4_in_ready", in_ready_3, 1);
        tick();
        check("t4_no_partial", out_valid_3, 0);
        pops_before = pops3;
        in_valid_3 = 1; in_a_3 = 1; in_b_3 = 1;
        tick();
        in_valid_3 = 0;
        wait_idle3("t4_idle");
        check("t4_results", pops3 - pops_before, 4);
        check("t4_token_count", token_count_3, 1);

        // Randomized traffic on the NUM_POST=3 instance
        for (int c = 0; c < 400; c++) begin
            in_valid_3  = 1'($urandom_range(0, 1));
            in_a_3      = 1'($urandom_range(0, 1));
            in_b_3      = 1'($urandom_range(0, 1));
            out_ready_3 = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid_3 = 0;
        out_ready_3 = 1;
        wait_idle3("rand_idle");
        check("rand_token_count", token_count_3, 8'(acc3));
        check("rand_queue_empty", exp_q3.size(), 0);

        // NUM_POST=0 instance: 2-cycle period, then run to the 256th completion
        in_valid_0 = 1;
        for (int t = 1; t <= 512; t++) begin
            in_a_0 = 1'($urandom_range(0, 1));
            in_b_0 = 1'($urandom_range(0, 1));
            tick();
            if (t <= 6) begin
                check("np0_state", state_0, (t % 2 == 1) ? 3'd0 : 3'd4);
                if (t % 2 == 0) check("np0_valid", out_valid_0, 1);
            end
            if (t == 6)   check("np0_token_count", token_count_0, 3);
            if (t == 510) check("wrap_255", token_count_0, 255);
            if (t == 512) check("wrap_0", token_count_0, 0);
        end
        in_valid_0 = 0;
        tick(); tick();
        check("np0_queue_empty", exp_q0.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
